// File: rtl/kbd_scan_seq.sv
// PS/2 scan-code sequencer: pops bytes from the receiver FIFO and tracks make/break/E0 state.
// Define KBD_ASCII_EN to enable the scan-code to ASCII lookup on key_ascii.
module kbd_scan_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ready,
  input  logic [7:0]       data,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic [7:0]       key_ascii,
  output logic             key_valid,
  output logic             key_down,
  output logic             extended,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_seen
);

  typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;

  state_t state;
  logic   ext_pend;
  logic   brk_pend;

`ifdef KBD_ASCII_EN
  function automatic logic [7:0] ascii_lut(input logic [7:0] code);
    logic [7:0] a;
    case (code)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20; 8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    return a;
  endfunction
`else
  assign key_ascii = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state      <= IDLE;
      nextdata_n <= 1'b1;
      key_code   <= 8'h00;
      key_valid  <= 1'b0;
      key_down   <= 1'b0;
      extended   <= 1'b0;
      press_cnt  <= '0;
      ovf_seen   <= 1'b0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
`ifdef KBD_ASCII_EN
      key_ascii  <= 8'h00;
`endif
    end else begin
      key_valid  <= 1'b0;
      nextdata_n <= 1'b1;
      if (overflow)
        ovf_seen <= 1'b1;
      case (state)
        IDLE: begin
          if (ready) begin
            // Byte is decoded at the accepting edge; POP/SETTLE only give the FIFO time to advance.
            state      <= POP;
            nextdata_n <= 1'b0;
            if (data == 8'hE0) begin
              ext_pend <= 1'b1;
            end else if (data == 8'hF0) begin
              brk_pend <= 1'b1;
            end else if (brk_pend) begin
              if (data == key_code && key_down)
                key_down <= 1'b0;
              ext_pend <= 1'b0;
              brk_pend <= 1'b0;
            end else if (key_down && data == key_code && ext_pend == extended) begin
              ext_pend <= 1'b0;
            end else begin
              key_code  <= data;
              extended  <= ext_pend;
              key_down  <= 1'b1;
              key_valid <= 1'b1;
              press_cnt <= press_cnt + 1'b1;
              ext_pend  <= 1'b0;
`ifdef KBD_ASCII_EN
              key_ascii <= ext_pend ? 8'h00 : ascii_lut(data);
`endif
            end
          end
        end
        POP:     state <= SETTLE;
        SETTLE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_scan_seq.sv
// Directed testbench for kbd_scan_seq: FIFO handshake, make/break/typematic, wrap, overflow, reset abort.
module tb_kbd_scan_seq;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] data = 8'h00;
  logic       overflow = 1'b0;
  logic       nextdata_n;
  logic [7:0] key_code;
  logic [7:0] key_ascii;
  logic       key_valid;
  logic       key_down;
  logic       extended;
  logic [7:0] press_cnt;
  logic       ovf_seen;

  int errors = 0;
  int checks = 0;
  int kv_cnt = 0;
  int pop_cnt = 0;

`ifdef KBD_ASCII_EN
  localparam logic [7:0] ASCII_A = 8'h61;
`else
  localparam logic [7:0] ASCII_A = 8'h00;
`endif

  kbd_scan_seq #(.CNT_W(8)) dut (
    .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
    .nextdata_n(nextdata_n), .key_code(key_code), .key_ascii(key_ascii),
    .key_valid(key_valid), .key_down(key_down), .extended(extended),
    .press_cnt(press_cnt), .ovf_seen(ovf_seen)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_valid === 1'b1) kv_cnt++;
    if (nextdata_n === 1'b0) pop_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte at the FIFO head for a single edge, then wait out POP and SETTLE.
  task automatic send(input logic [7:0] b);
    ready = 1'b1;
    data  = b;
    tick();
    ready = 1'b0;
    data  = 8'h00;
    tick();
    tick();
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    tick();
    tick();
    clrn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({nextdata_n, key_code, key_ascii, key_valid, key_down, extended, press_cnt, ovf_seen} !==
        {1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got nd=%b code=%h asc=%h kv=%b kd=%b ext=%b cnt=%h ovf=%b, want 1/00/00/0/0/0/00/0",
               nextdata_n, key_code, key_ascii, key_valid, key_down, extended, press_cnt, ovf_seen);
    end
  endtask

  task automatic test_single_make();
    int p0;
    p0 = pop_cnt;
    ready = 1'b1;
    data  = 8'h1C;
    tick();
    ready = 1'b0;
    data  = 8'h00;
    checks++;
    if ({nextdata_n, key_valid, key_down, key_code, press_cnt, key_ascii} !==
        {1'b0, 1'b1, 1'b1, 8'h1C, 8'h01, ASCII_A}) begin
      errors++;
      $display("FAIL make_cycle1: got nd=%b kv=%b kd=%b code=%h cnt=%h asc=%h, want 0/1/1/1c/01/%h",
               nextdata_n, key_valid, key_down, key_code, press_cnt, key_ascii, ASCII_A);
    end
    tick();
    checks++;
    if ({nextdata_n, key_valid, key_down} !== 3'b101) begin
      errors++;
      $display("FAIL make_cycle2: got nd=%b kv=%b kd=%b, want 1/0/1", nextdata_n, key_valid, key_down);
    end
    tick();
    checks++;
    if (pop_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL make_pops: got %0d want 1", pop_cnt - p0);
    end
  endtask

  task automatic test_typematic_break();
    int kv0, p0;
    do_reset();
    kv0 = kv_cnt;
    p0 = pop_cnt;
    send(8'h1C); send(8'h1C); send(8'h1C);
    checks++;
    if ({key_down, press_cnt, pop_cnt - p0} !== {1'b1, 8'h01, 32'd3}) begin
      errors++;
      $display("FAIL typematic: got kd=%b cnt=%h pops=%0d, want 1/01/3", key_down, press_cnt, pop_cnt - p0);
    end
    send(8'hF0); send(8'h1C);
    checks++;
    if ({key_down, press_cnt, kv_cnt - kv0, pop_cnt - p0} !== {1'b0, 8'h01, 32'd1, 32'd5}) begin
      errors++;
      $display("FAIL break: got kd=%b cnt=%h kv=%0d pops=%0d, want 0/01/1/5",
               key_down, press_cnt, kv_cnt - kv0, pop_cnt - p0);
    end
  endtask

  task automatic test_stray_break();
    send(8'h32);
    send(8'hF0); send(8'h1C);
    checks++;
    if ({key_down, key_code, press_cnt} !== {1'b1, 8'h32, 8'h02}) begin
      errors++;
      $display("FAIL stray_break: got kd=%b code=%h cnt=%h, want 1/32/02", key_down, key_code, press_cnt);
    end
    send(8'hF0); send(8'h32);
  endtask

  task automatic test_extended();
    int kv0;
    do_reset();
    send(8'h75);
    kv0 = kv_cnt;
    send(8'hE0); send(8'h75);
    checks++;
    if ({key_code, extended, key_ascii, key_down, press_cnt, kv_cnt - kv0} !==
        {8'h75, 1'b1, 8'h00, 1'b1, 8'h02, 32'd1}) begin
      errors++;
      $display("FAIL ext_make: got code=%h ext=%b asc=%h kd=%b cnt=%h kv=%0d, want 75/1/00/1/02/1",
               key_code, extended, key_ascii, key_down, press_cnt, kv_cnt - kv0);
    end
    send(8'hE0); send(8'hF0); send(8'h75);
    checks++;
    if ({key_code, extended, key_down} !== {8'h75, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ext_break: got code=%h ext=%b kd=%b, want 75/1/0", key_code, extended, key_down);
    end
  endtask

  task automatic test_wrap();
    int kv0;
    do_reset();
    kv0 = kv_cnt;
    for (int i = 0; i < 255; i++) send((i % 2 == 0) ? 8'h1C : 8'h32);
    checks++;
    if (press_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_255: got %h want ff", press_cnt);
    end
    send(8'h32);
    checks++;
    if ({press_cnt, kv_cnt - kv0} !== {8'h00, 32'd256}) begin
      errors++;
      $display("FAIL wrap_256: got cnt=%h kv=%0d, want 00/256", press_cnt, kv_cnt - kv0);
    end
  endtask

  task automatic test_overflow();
    checks++;
    if (ovf_seen !== 1'b0) begin
      errors++;
      $display("FAIL ovf_before: got %b want 0", ovf_seen);
    end
    overflow = 1'b1;
    tick();
    overflow = 1'b0;
    checks++;
    if (ovf_seen !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b want 1", ovf_seen);
    end
    send(8'h1C); send(8'hF0); send(8'h1C);
    checks++;
    if ({ovf_seen, key_down} !== 2'b10) begin
      errors++;
      $display("FAIL ovf_sticky: got ovf=%b kd=%b want 1/0", ovf_seen, key_down);
    end
  endtask

  task automatic test_reset_abort();
    ready = 1'b1;
    data  = 8'h1C;
    tick();
    ready = 1'b0;
    clrn  = 1'b0;
    tick();
    checks++;
    if ({nextdata_n, key_code, key_ascii, key_valid, key_down, extended, press_cnt, ovf_seen} !==
        {1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL abort_reset: got nd=%b code=%h asc=%h kv=%b kd=%b ext=%b cnt=%h ovf=%b, want 1/00/00/0/0/0/00/0",
               nextdata_n, key_code, key_ascii, key_valid, key_down, extended, press_cnt, ovf_seen);
    end
    clrn = 1'b1;
    tick();
    checks++;
    if ({nextdata_n, key_valid} !== 2'b10) begin
      errors++;
      $display("FAIL abort_idle: got nd=%b kv=%b want 1/0", nextdata_n, key_valid);
    end
    send(8'h1C);
    checks++;
    if ({key_code, key_down, press_cnt, key_ascii} !== {8'h1C, 1'b1, 8'h01, ASCII_A}) begin
      errors++;
      $display("FAIL abort_remake: got code=%h kd=%b cnt=%h asc=%h, want 1c/1/01/%h",
               key_code, key_down, press_cnt, key_ascii, ASCII_A);
    end
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_typematic_break();
    test_stray_break();
    test_extended();
    test_wrap();
    test_overflow();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
